lcd_write_arbiter: RTL and testbench
====================================

LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter T_SETUP, default 2: clk cycles that RS/DB are stable before E rises.
REQ-002 Parameter T_EN, default 12: clk cycles E is held high (240 ns at 50 MHz).
REQ-003 Parameter T_HOLD, default 1: clk cycles RS/DB are held after E falls.
REQ-004 Parameter T_NIB, default 50: clk cycles of gap between the high and low nibble (1 us).
REQ-005 Parameter T_BYTE, default 2000: clk cycles of settle time after a normal byte (40 us).
REQ-006 Parameter T_CLR, default 82000: clk cycles of settle time after a clear/home command (1.64 ms).
REQ-007 Port list, one per line:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  init sequencer requests a byte write.
- init_rs  in  1  RS value for the init byte.
- init_data  in  8  init byte.
- init_ack  out  1  one-cycle pulse, init byte fully written.
- init_done  in  1  high once power-on init is complete.
- usr_req  in  1  user/display requests a byte write.
- usr_rs  in  1  RS value for the user byte.
- usr_data  in  8  user byte.
- usr_ack  out  1  one-cycle pulse, user byte fully written.
- busy  out  1  high while any byte transfer is in progress.
- lcd_e  out  1  LCD enable.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; tied to 0 (write only).
- lcd_db  out  4  LCD data nibble (DB7..DB4).

Function
REQ-008 The block SHALL use this FSM: IDLE, H_SETUP, H_EN, H_HOLD, GAP, L_SETUP, L_EN, L_HOLD, SETTLE, ACK.
REQ-009 In IDLE with init_req=1, the block SHALL grant init; otherwise, with usr_req=1 and init_done=1, it SHALL grant user; grant evaluation is strict priority with init first.
REQ-010 usr_req SHALL be ignored while init_done=0.
REQ-011 On a grant, the block SHALL latch rs, data and the owner, and SHALL enter H_SETUP on the next cycle; later changes on request inputs SHALL NOT affect the transfer in progress.
REQ-012 H_SETUP: lcd_db=data[7:4], lcd_rs=rs, lcd_e=0, for T_SETUP cycles.
REQ-013 H_EN: same data, lcd_e=1, for T_EN cycles.
REQ-014 H_HOLD: lcd_e=0, data held, for T_HOLD cycles.
REQ-015 GAP: lcd_e=0 for T_NIB cycles.
REQ-016 L_SETUP, L_EN and L_HOLD SHALL repeat REQ-012 to REQ-014 with lcd_db=data[3:0].
REQ-017 SETTLE SHALL last T_CLR cycles when rs=0 and data is 0x01 or 0x02 or 0x03; otherwise it SHALL last T_BYTE cycles.
REQ-018 ACK SHALL last exactly 1 cycle, pulsing the owner's ack only, then return to IDLE.
REQ-019 A request still high in IDLE SHALL be treated as a new byte; requesters SHALL drop req on ack.
REQ-020 Simultaneous init_req and usr_req SHALL serve init first; user is served on the following IDLE if init_req is then low.
REQ-021 The wait counter SHALL be 17 bits, reload on each state entry and count down to 0, with no wrap.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 lcd_e SHALL be high only in H_EN and L_EN.
REQ-024 lcd_rw SHALL always be 0.

Reset
REQ-025 With rst_n=0, the block SHALL immediately enter IDLE and drive lcd_e=0, lcd_rs=0, lcd_db=0, init_ack=0, usr_ack=0, busy=0, and counter=0.
REQ-026 Reset mid-transfer SHALL abort the transfer with no ack; after release, the block SHALL resume arbitration from IDLE on the first clk edge.

Verification
REQ-027 init_req=1, rs=0, data=0x28 -> lcd_db=0x2 with E high for 12 cycles, then 0x0 with E high for 12 cycles; init_ack pulses 1 cycle at 2+12+1+50+2+12+1+2000+1 cycles after the grant.
REQ-028 init_done=0, usr_req=1 for 5000 cycles -> no lcd_e activity, usr_ack=0, busy=0.
REQ-029 init_req and usr_req high in the same cycle with init_done=1 -> init byte completes first; the user byte starts in the IDLE that follows init_ack.
REQ-030 User rs=0, data=0x01 -> SETTLE lasts 82000 cycles; user rs=1, data=0x01 -> SETTLE lasts 2000 cycles.
REQ-031 rst_n pulsed low during L_EN -> lcd_e=0 immediately, no ack, busy=0; a held request restarts from the high nibble.
REQ-032 usr_data changed mid-transfer from 0x41 to 0x42 -> the transmitted nibbles are 0x4 then 0x1.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: arbitrates init/user byte writes onto a 4-bit HD44780-style LCD bus
module lcd_write_arbiter #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 1,
  parameter int T_NIB   = 50,
  parameter int T_BYTE  = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       init_rs,
  input  logic [7:0] init_data,
  output logic       init_ack,
  input  logic       init_done,
  input  logic       usr_req,
  input  logic       usr_rs,
  input  logic [7:0] usr_data,
  output logic       usr_ack,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_db
);
  typedef enum logic [3:0] {IDLE, H_SETUP, H_EN, H_HOLD, GAP, L_SETUP, L_EN, L_HOLD, SETTLE, ACK} state_t;
  state_t      state, nxt;
  logic [16:0] cnt, dur;
  logic [7:0]  data_q;
  logic        rs_q, own_q, clr, hi;
  assign clr = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  // next state: IDLE arbitrates (init first, user only after init_done); timed states advance when the counter drains
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (init_req || (usr_req && init_done)) ? H_SETUP : IDLE;
      H_SETUP: nxt = H_EN;
      H_EN:    nxt = H_HOLD;
      H_HOLD:  nxt = GAP;
      GAP:     nxt = L_SETUP;
      L_SETUP: nxt = L_EN;
      L_EN:    nxt = L_HOLD;
      L_HOLD:  nxt = SETTLE;
      SETTLE:  nxt = ACK;
      default: nxt = IDLE;
    endcase
    if (state != IDLE && cnt != 17'd0) nxt = state;
  end
  assign dur = (nxt == H_SETUP || nxt == L_SETUP) ? 17'(T_SETUP - 1) :
               (nxt == H_EN || nxt == L_EN)       ? 17'(T_EN - 1) :
               (nxt == H_HOLD || nxt == L_HOLD)   ? 17'(T_HOLD - 1) :
               (nxt == GAP)                       ? 17'(T_NIB - 1) :
               (nxt == SETTLE)                    ? (clr ? 17'(T_CLR - 1) : 17'(T_BYTE - 1)) : 17'd0;
  // state register, wait counter reloaded on every state change, and the granted byte latched at grant time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 17'd0;
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      own_q  <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? dur : (cnt != 17'd0) ? cnt - 17'd1 : cnt;
      if (state == IDLE && nxt == H_SETUP) begin
        own_q  <= !init_req;
        rs_q   <= init_req ? init_rs : usr_rs;
        data_q <= init_req ? init_data : usr_data;
      end
    end
  end
  assign hi       = state inside {H_SETUP, H_EN, H_HOLD, GAP};
  assign lcd_db   = (state == IDLE) ? 4'h0 : hi ? data_q[7:4] : data_q[3:0];
  assign lcd_rs   = (state != IDLE) && rs_q;
  assign lcd_e    = (state == H_EN) || (state == L_EN);
  assign lcd_rw   = 1'b0;
  assign busy     = state != IDLE;
  assign init_ack = (state == ACK) && !own_q;
  assign usr_ack  = (state == ACK) && own_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: randomized self-checking bench against a phase-timeline model of the LCD write
module tb_lcd_write_arbiter;
  localparam int S = 2, EN = 3, H = 1, NIB = 4, BYTE = 20, CLR = 60;
  logic clk, rst_n, init_req, init_rs, init_done, usr_req, usr_rs;
  logic [7:0] init_data, usr_data;
  logic init_ack, usr_ack, busy, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_db;
  int errors = 0, checks = 0;

  lcd_write_arbiter #(.T_SETUP(S), .T_EN(EN), .T_HOLD(H), .T_NIB(NIB), .T_BYTE(BYTE), .T_CLR(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_rs(init_rs), .init_data(init_data),
    .init_ack(init_ack), .init_done(init_done), .usr_req(usr_req), .usr_rs(usr_rs),
    .usr_data(usr_data), .usr_ack(usr_ack), .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_db(lcd_db));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic issue(input bit own, input bit rs, input logic [7:0] d);
    @(negedge clk);
    if (own) begin usr_req = 1; usr_rs = rs; usr_data = d; end
    else begin init_req = 1; init_rs = rs; init_data = d; end
  endtask

  // Follows one byte from the cycle after grant; optionally corrupts the requester inputs or resets mid-way.
  task automatic run_byte(input bit own, input bit rs, input logic [7:0] d, input int mut_idx, input int rst_idx);
    int settle, e1, e2, tot;
    bit exp_e;
    logic [1:0] exp_ack;
    settle = (!rs && d >= 8'd1 && d <= 8'd3) ? CLR : BYTE;
    e1 = S;
    e2 = S + EN + H + NIB + S;
    tot = e2 + EN + H + settle;
    for (int idx = 0; idx <= tot; idx++) begin
      @(negedge clk);
      if (idx == rst_idx) begin
        rst_n = 0;
        #1;
        checks++;
        if ({lcd_e, busy, init_ack, usr_ack, lcd_rs, lcd_db} !== 9'd0) begin
          errors++;
          $display("FAIL rst_abort idx=%0d got e/busy/ia/ua/rs/db=%b required all zero", idx,
                   {lcd_e, busy, init_ack, usr_ack, lcd_rs, lcd_db});
        end
        return;
      end
      exp_e = (idx >= e1 && idx < e1 + EN) || (idx >= e2 && idx < e2 + EN);
      checks++;
      if ({lcd_e, busy, lcd_rw} !== {exp_e, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL ctl idx=%0d got e/busy/rw=%b required %b", idx, {lcd_e, busy, lcd_rw}, {exp_e, 2'b10});
      end
      if (idx < e1 + EN + H) begin
        checks++;
        if ({lcd_rs, lcd_db} !== {rs, d[7:4]}) begin
          errors++;
          $display("FAIL hi_nib idx=%0d got rs/db=%h required %h", idx, {lcd_rs, lcd_db}, {rs, d[7:4]});
        end
      end
      if (idx >= e2 - S && idx < e2 + EN + H) begin
        checks++;
        if ({lcd_rs, lcd_db} !== {rs, d[3:0]}) begin
          errors++;
          $display("FAIL lo_nib idx=%0d got rs/db=%h required %h", idx, {lcd_rs, lcd_db}, {rs, d[3:0]});
        end
      end
      exp_ack = (idx == tot) ? (own ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if ({init_ack, usr_ack} !== exp_ack) begin
        errors++;
        $display("FAIL ack idx=%0d got init/usr=%b required %b", idx, {init_ack, usr_ack}, exp_ack);
      end
      if (idx == mut_idx) begin
        usr_data = 8'h42; usr_rs = ~usr_rs;
        init_data = 8'($urandom); init_rs = ~init_rs;
      end
      if (idx == tot) begin
        if (own) usr_req = 0;
        else init_req = 0;
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if ({busy, lcd_e, init_ack, usr_ack} !== 4'b0) begin
      errors++;
      $display("FAIL %s got busy/e/ia/ua=%b required 0000", name, {busy, lcd_e, init_ack, usr_ack});
    end
  endtask

  task automatic test_reset;
    rst_n = 0; init_req = 0; init_rs = 0; init_data = 0; init_done = 0;
    usr_req = 0; usr_rs = 0; usr_data = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_db, init_ack, usr_ack, busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset got %b required all zero", {lcd_e, lcd_rs, lcd_rw, lcd_db, init_ack, usr_ack, busy});
    end
    @(negedge clk);
    rst_n = 1;
    check_idle("reset_release");
  endtask

  task automatic test_init_byte;
    issue(0, 0, 8'h28);
    run_byte(0, 0, 8'h28, -1, -1);
    check_idle("init_idle");
  endtask

  task automatic test_usr_gated;
    @(negedge clk);
    usr_req = 1; usr_rs = 1; usr_data = 8'h55;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, lcd_e, usr_ack} !== 3'b0) begin
        errors++;
        $display("FAIL usr_gated cyc=%0d got busy/e/ua=%b required 000", i, {busy, lcd_e, usr_ack});
      end
    end
    usr_req = 0;
    init_done = 1;
    check_idle("gated_end");
  endtask

  task automatic test_priority;
    @(negedge clk);
    init_req = 1; init_rs = 1; init_data = 8'hA5;
    usr_req = 1; usr_rs = 0; usr_data = 8'h3C;
    run_byte(0, 1, 8'hA5, -1, -1);
    check_idle("prio_gap");
    run_byte(1, 0, 8'h3C, -1, -1);
    check_idle("prio_end");
  endtask

  task automatic test_clear;
    issue(1, 0, 8'h01);
    run_byte(1, 0, 8'h01, -1, -1);
    check_idle("clr_idle");
    issue(1, 1, 8'h01);
    run_byte(1, 1, 8'h01, -1, -1);
    check_idle("clr_rs1_idle");
    issue(0, 0, 8'h03);
    run_byte(0, 0, 8'h03, -1, -1);
    check_idle("home_idle");
    issue(1, 0, 8'h04);
    run_byte(1, 0, 8'h04, -1, -1);
    check_idle("byte4_idle");
  endtask

  task automatic test_latch;
    issue(1, 1, 8'h41);
    run_byte(1, 1, 8'h41, 3, -1);
    check_idle("latch_idle");
  endtask

  task automatic test_reset_mid;
    issue(1, 1, 8'h7E);
    run_byte(1, 1, 8'h7E, -1, S + EN + H + NIB + S + 1);
    @(negedge clk);
    checks++;
    if ({busy, lcd_e, usr_ack} !== 3'b0) begin
      errors++;
      $display("FAIL rst_hold got busy/e/ua=%b required 000", {busy, lcd_e, usr_ack});
    end
    rst_n = 1;
    run_byte(1, 1, 8'h7E, -1, -1);
    check_idle("rst_restart_idle");
  endtask

  task automatic test_random;
    bit own, rs;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      own = 1'($urandom);
      rs = 1'($urandom);
      d = ($urandom % 3 == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      issue(own, rs, d);
      run_byte(own, rs, d, ($urandom % 2) ? int'($urandom_range(0, 15)) : -1, -1);
      check_idle("rand_idle");
    end
  endtask

  initial begin
    test_reset;
    test_init_byte;
    test_usr_gated;
    test_priority;
    test_clear;
    test_latch;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
